ysyx_22040088_fetch_queue: RTL and testbench

//  Parametrised decoupled instruction fetch stage with valid/ready handshakes on both sides.

---
 rtl/ysyx_22040088_fetch_queue.sv | 102 ++++++++++
 tb/tb_ysyx_22040088_fetch_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040088_fetch_queue.sv
// Decoupled instruction fetch queue: issues in-order PC-tagged requests to
// instruction memory, buffers up to DEPTH instructions and hands {inst, pc}
// pairs to the decoder. A redirect flushes the queue and discards stale
// in-flight responses.
module ysyx_22040088_fetch_queue #(
   parameter int              XLEN     = 64,
   parameter int              ILEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [ILEN-1:0] imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [ILEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc
);

   localparam int PW = $clog2(DEPTH) + 1;
   localparam int AW = PW - 1;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] pc_q   [DEPTH];
   logic [ILEN-1:0] data_q [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] fill;
   logic [PW-1:0] tail;
   logic [PW-1:0] drop_cnt;

   logic [PW-1:0] count;
   logic [PW-1:0] pending;
   logic [PW:0]   occupancy;
   logic          full;
   logic          req_fire;
   logic          deq_fire;
   logic          resp_drop;
   logic          resp_fill;
   logic          resp_take;

   assign count     = tail - head;
   assign pending   = tail - fill;
   // Discarded responses still occupy request slots until they return.
   assign occupancy = {1'b0, count} + {1'b0, drop_cnt};
   assign full      = occupancy >= (PW+1)'(DEPTH);

   assign imem_req_valid = rst && !full && !redirect_valid;
   assign imem_req_addr  = rst ? fetch_pc : RESET_PC;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign inst_valid = rst && (head != fill) && !redirect_valid;
   assign inst       = data_q[head[AW-1:0]];
   assign inst_pc    = pc_q[head[AW-1:0]];
   assign deq_fire   = inst_valid && inst_ready;

   // A response with nothing pending and nothing to drop is ignored.
   assign resp_drop = imem_resp_valid && (drop_cnt != '0);
   assign resp_fill = imem_resp_valid && (drop_cnt == '0) && (pending != '0);
   assign resp_take = resp_drop || resp_fill;

   // Pointer, drop counter and fetch PC update; redirect overrides all else.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         head     <= '0;
         fill     <= '0;
         tail     <= '0;
         drop_cnt <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc & ~XLEN'(3);
         head     <= tail;
         fill     <= tail;
         drop_cnt <= drop_cnt + pending - PW'(resp_take);
      end else begin
         if (req_fire) begin
            tail     <= tail + PW'(1);
            fetch_pc <= fetch_pc + XLEN'(4);
         end
         if (resp_drop) drop_cnt <= drop_cnt - PW'(1);
         if (resp_fill) fill <= fill + PW'(1);
         if (deq_fire)  head <= head + PW'(1);
      end
   end

   // Entry storage: PC tag written at request, instruction at response.
   always_ff @(posedge clk) begin
      if (req_fire) pc_q[tail[AW-1:0]] <= fetch_pc;
      if (rst && !redirect_valid && resp_fill) data_q[fill[AW-1:0]] <= imem_resp_data;
   end

   // Responses must match an outstanding or to-be-dropped request.
   resp_protocol : assert property (@(posedge clk) disable iff (!rst)
      imem_resp_valid |-> ((pending != '0) || (drop_cnt != '0)));

endmodule

// File: tb/tb_ysyx_22040088_fetch_queue.sv
// Directed testbench for the fetch queue with an in-order fixed-latency
// instruction memory model.
module tb_ysyx_22040088_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int lat   = 1;

   logic [63:0] mq_addr[$];
   int          mq_due[$];
   logic [63:0] req_log[$];
   logic [63:0] deq_pc[$];
   logic [31:0] deq_inst[$];

   ysyx_22040088_fetch_queue #(
      .XLEN(64), .ILEN(32), .DEPTH(4), .RESET_PC(64'h8000_0000)
   ) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [63:0] req_at(input int i);
      return (i < req_log.size()) ? req_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction

   function automatic logic [63:0] pc_at(input int i);
      return (i < deq_pc.size()) ? deq_pc[i] : 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction

   function automatic logic [31:0] inst_at(input int i);
      return (i < deq_inst.size()) ? deq_inst[i] : 32'hDEAD_DEAD;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: record fires, advance, then present any due memory response.
   task automatic tick();
      logic rf, df, rst_at_edge;
      #1;
      rf = imem_req_valid && imem_req_ready;
      df = inst_valid && inst_ready;
      if (rf) begin
         req_log.push_back(imem_req_addr);
         mq_addr.push_back(imem_req_addr);
         mq_due.push_back(cyc + lat);
      end
      if (df) begin
         deq_pc.push_back(inst_pc);
         deq_inst.push_back(inst);
      end
      rst_at_edge = rst;
      @(posedge clk);
      cyc++;
      #1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      if (!rst_at_edge) begin
         mq_addr.delete();
         mq_due.delete();
      end else if (mq_due.size() > 0 && mq_due[0] == cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(mq_addr[0]);
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
   endtask

   task automatic clear_logs();
      req_log.delete();
      deq_pc.delete();
      deq_inst.delete();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      redirect_valid = 1'b0;
      repeat (n) tick();
      rst = 1'b1;
      clear_logs();
      #1;
   endtask

   task automatic wait_deq(input int n, input int budget);
      int b;
      b = budget;
      while (deq_pc.size() < n && b > 0) begin
         tick();
         b--;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      inst_ready      = 1'b1;

      // 1: reset values, first-instruction latency, one per cycle
      lat = 1;
      rst = 1'b0;
      tick();
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_addr", imem_req_addr, 64'h8000_0000);
      tick();
      rst = 1'b1;
      clear_logs();
      #1;
      check("t1_req_valid", imem_req_valid, 1);
      check("t1_addr", imem_req_addr, 64'h8000_0000);
      tick();
      check("t1_lat_n1", inst_valid, 0);
      tick();
      check("t1_lat_n2", inst_valid, 1);
      check("t1_pc0", inst_pc, 64'h8000_0000);
      check("t1_inst0", inst, mem_word(64'h8000_0000));
      tick();
      check("t1_pc1", inst_pc, 64'h8000_0004);
      tick();
      check("t1_pc2", inst_pc, 64'h8000_0008);
      check("t1_inst2", inst, mem_word(64'h8000_0008));

      // 2: decoder stalled, queue fills to DEPTH then drains in order
      inst_ready = 1'b0;
      do_reset(1);
      repeat (8) tick();
      check("t2_req_cnt", req_log.size(), 4);
      check("t2_req0", req_at(0), 64'h8000_0000);
      check("t2_req3", req_at(3), 64'h8000_000C);
      check("t2_full_req_valid", imem_req_valid, 0);
      inst_ready = 1'b1;
      #1;
      check("t2_full_deq_no_req", imem_req_valid, 0);
      repeat (8) tick();
      check("t2_deq0", pc_at(0), 64'h8000_0000);
      check("t2_deq1", pc_at(1), 64'h8000_0004);
      check("t2_deq2", pc_at(2), 64'h8000_0008);
      check("t2_deq3", pc_at(3), 64'h8000_000C);
      check("t2_inst3", inst_at(3), mem_word(64'h8000_000C));
      check("t2_resume", req_at(4), 64'h8000_0010);

      // 3: redirect with two outstanding, none filled, latency 3
      lat = 3;
      inst_ready = 1'b1;
      do_reset(1);
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0100;
      #1;
      check("t3_redir_blocks_req", imem_req_valid, 0);
      tick();
      redirect_valid = 1'b0;
      wait_deq(1, 20);
      check("t3_deq_cnt", deq_pc.size(), 1);
      check("t3_first_pc", pc_at(0), 64'h8000_0100);
      check("t3_first_inst", inst_at(0), mem_word(64'h8000_0100));
      check("t3_req2", req_at(2), 64'h8000_0100);

      // 4: redirect coincides with a response, one other outstanding
      lat = 2;
      do_reset(1);
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0200;
      tick();
      redirect_valid = 1'b0;
      #1;
      check("t4_addr_after", imem_req_addr, 64'h8000_0200);
      check("t4_req_valid", imem_req_valid, 1);
      wait_deq(2, 20);
      check("t4_first_pc", pc_at(0), 64'h8000_0200);
      check("t4_first_inst", inst_at(0), mem_word(64'h8000_0200));
      check("t4_second_pc", pc_at(1), 64'h8000_0204);

      // 5: memory back-pressure holds the request stable
      lat = 1;
      imem_req_ready = 1'b0;
      do_reset(1);
      for (int i = 0; i < 3; i++) begin
         check("t5_hold_valid", imem_req_valid, 1);
         check("t5_hold_addr", imem_req_addr, 64'h8000_0000);
         tick();
      end
      imem_req_ready = 1'b1;
      tick();
      check("t5_one_req", req_log.size(), 1);
      check("t5_next_addr", imem_req_addr, 64'h8000_0004);

      // 6: reset mid-stream with three filled entries, then redirect
      inst_ready = 1'b0;
      do_reset(1);
      repeat (4) tick();
      check("t6_pre_valid", inst_valid, 1);
      check("t6_pre_pc", inst_pc, 64'h8000_0000);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      clear_logs();
      #1;
      check("t6_post_inst_valid", inst_valid, 0);
      check("t6_post_addr", imem_req_addr, 64'h8000_0000);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0103;
      tick();
      redirect_valid = 1'b0;
      #1;
      check("t6_redir_addr", imem_req_addr, 64'h8000_0100);
      inst_ready = 1'b1;
      wait_deq(1, 20);
      check("t6_first_pc", pc_at(0), 64'h8000_0100);
      check("t6_first_inst", inst_at(0), mem_word(64'h8000_0100));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
